sw1_req_arb: RTL and testbench
==============================

Name: sw1_req_arb

Overview:
- Request arbiter and response router directly downstream of the SW ping-pong test engine (test_sw1) in the NLB AFU.
- Accepts the engine's single-beat read and write requests, issues them on the CCI-P TX channels c0 (read) and c1 (write), and tags each one in mdata.
- Routes RX read, write and UMsg responses back to the engine with the original request address restored.
- Tracks outstanding requests per channel, applies back-pressure, and reports orphan responses.

Parameters:
- ADDR_LMT, 20, cache-line address width.
- MAX_OUTST, 16, tag-table depth per channel; power of 2, 2..256.
- PEND_THRESH, 1, free-slot margin at which write almost-full asserts.

Ports:
- Clk_400  in  1  core clock.
- test_Resetb  in  1  synchronous active-low reset.
- s12ab_WrAddr  in  ADDR_LMT  write address.
- s12ab_WrTID  in  16  write TID.
- s12ab_WrDin  in  21  write payload, zero-extended to 512.
- s12ab_WrFence  in  1  write fence request.
- s12ab_WrEn  in  1  write request.
- ab2s1_WrSent  out  1  write issued pulse.
- ab2s1_WrAlmFull  out  1  write back-pressure.
- s12ab_RdAddr  in  ADDR_LMT  read address.
- s12ab_RdTID  in  16  read TID.
- s12ab_RdEn  in  1  read request.
- ab2s1_RdSent  out  1  read issued pulse.
- ab2s1_RdRspValid  out  1  read response valid.
- ab2s1_UMsgValid  out  1  UMsg valid.
- ab2s1_RdRsp  out  16  response header (RX mdata).
- ab2s1_RdRspAddr  out  ADDR_LMT  restored read address.
- ab2s1_RdData  out  512  read data.
- ab2s1_WrRspValid  out  1  write response valid.
- ab2s1_WrRsp  out  16  RX mdata.
- ab2s1_WrRspAddr  out  ADDR_LMT  restored write address.
- s12ab_TestCmp  in  1  engine test complete.
- tx_c0_valid  out  1  read request valid.
- tx_c0_addr  out  ADDR_LMT  read address.
- tx_c0_mdata  out  16  read mdata.
- tx_c0_almfull  in  1  c0 almost-full.
- tx_c1_valid  out  1  write or fence valid.
- tx_c1_fence  out  1  beat is a fence.
- tx_c1_addr  out  ADDR_LMT  write address.
- tx_c1_mdata  out  16  write mdata.
- tx_c1_data  out  512  write data.
- tx_c1_almfull  in  1  c1 almost-full.
- rx_c0_rdvalid  in  1  read response.
- rx_c0_umsgvalid  in  1  UMsg.
- rx_c0_mdata  in  16  response mdata / UMsg header.
- rx_c0_data  in  512  response data.
- rx_c1_wrvalid  in  1  write response.
- rx_c1_mdata  in  16  write response mdata.
- arb_test_done  out  1  sticky: TestCmp seen and no requests outstanding.
- err_orphan_rsp  out  1  sticky: response hit an invalid tag.

Behaviour:
- Reset (synchronous, test_Resetb=0 at posedge):
  - all outputs 0;
  - all tag valid bits cleared;
  - alloc pointers and outstanding counters 0;
  - sticky flags cleared.
- Tag format: mdata[15:8] = TID[7:0]; mdata[7:0] = tag index (upper index bits 0 when MAX_OUTST<256).
- Each channel keeps a table of MAX_OUTST entries {valid, addr}.
- Tag allocation is in order from a wrapping pointer.
- Write issue condition in cycle N:
  - WrEn=1, WrSent=0, tx_c1_almfull=0, and wtable[wptr].valid=0 as registered at start of N.
  - In cycle N+1: tx_c1_valid=1 with addr, mdata and data registered; ab2s1_WrSent=1 for exactly one cycle.
  - In cycle N: entry set valid with WrAddr; wptr increments mod MAX_OUTST.
  - Requests presented while WrSent=1 are ignored (guards the engine's combinational WrEn/WrSent deassert).
- Fence beat (WrFence=1 with WrEn=1): issued as tx_c1_valid+tx_c1_fence, mdata=0, no tag allocated, WrSent still pulses.
- Read issue: identical on c0 using RdEn, RdSent, tx_c0_almfull and rtable. No data.
- ab2s1_WrAlmFull (registered) = tx_c1_almfull OR (write outstanding count >= MAX_OUTST-PEND_THRESH).
- Responses, 1-cycle registered latency:
  - rx_c0_rdvalid with valid rtable[mdata[7:0]]: next cycle RdRspValid=1, RdRspAddr=table addr, RdRsp=rx_c0_mdata, RdData=rx_c0_data; entry cleared.
  - rx_c0_umsgvalid (rdvalid=0): next cycle UMsgValid=1, RdRsp=rx_c0_mdata, RdData=rx_c0_data, no lookup.
  - rdvalid and umsgvalid together: read wins, UMsg dropped.
  - rx_c1_wrvalid: same as a read response via wtable, driving WrRspValid/WrRspAddr/WrRsp.
  - Response to an invalid entry: dropped, no valid out, err_orphan_rsp set. Includes stale responses arriving after a mid-run reset.
- Same-cycle response clear and allocation check on the same entry: allocation sees the old valid=1 and stalls one cycle.
- Outstanding counters: +1 on issue, -1 on a valid response; simultaneous issue and response leaves the count unchanged.
- arb_test_done set the cycle after s12ab_TestCmp=1 with both counters 0; held until reset.

Test Plan:
- Reset, then single write WrAddr=0x0FFE0, TID=0x20, WrDin=1 → tx_c1_valid and WrSent one cycle later, tx_c1_mdata=0x2000; wrvalid mdata=0x2000 → WrRspValid with WrRspAddr=0x0FFE0 next cycle.
- Read at 0x0FFE0 with RdEn held two cycles → exactly one tx_c0_valid; rdvalid mdata=0x2000, data[20:0]=2 → RdRspAddr=0x0FFE0, RdData[20:0]=2.
- 16 writes with no responses, MAX_OUTST=16 → WrAlmFull rises once the count reaches 15; the 17th write stalls until a response frees tag 0, then issues.
- tx_c0_almfull=1 with RdEn=1 for 10 cycles → no issue and no RdSent; almfull deasserted → issue on the next cycle.
- rdvalid and umsgvalid in the same cycle, then wrvalid with mdata=0x0005 (tag 5 invalid) → only RdRspValid is produced; err_orphan_rsp=1.
- Reset asserted with 3 reads outstanding, then TestCmp=1 → counters 0 and arb_test_done=1; a late response sets err_orphan_rsp.

Source files
------------

// File: rtl/sw1_req_arb.sv
// Tags engine read/write requests into CCI-P c0/c1 and routes tagged responses back with their address.
// Latency: requests and responses each take 1 registered cycle; backpressure from almfull inputs or a busy tag slot.
module sw1_req_arb #(
    parameter int ADDR_LMT    = 20,
    parameter int MAX_OUTST   = 16,
    parameter int PEND_THRESH = 1
) (
    input  logic                Clk_400,
    input  logic                test_Resetb,
    input  logic [ADDR_LMT-1:0] s12ab_WrAddr,
    input  logic [15:0]         s12ab_WrTID,
    input  logic [20:0]         s12ab_WrDin,
    input  logic                s12ab_WrFence,
    input  logic                s12ab_WrEn,
    output logic                ab2s1_WrSent,
    output logic                ab2s1_WrAlmFull,
    input  logic [ADDR_LMT-1:0] s12ab_RdAddr,
    input  logic [15:0]         s12ab_RdTID,
    input  logic                s12ab_RdEn,
    output logic                ab2s1_RdSent,
    output logic                ab2s1_RdRspValid,
    output logic                ab2s1_UMsgValid,
    output logic [15:0]         ab2s1_RdRsp,
    output logic [ADDR_LMT-1:0] ab2s1_RdRspAddr,
    output logic [511:0]        ab2s1_RdData,
    output logic                ab2s1_WrRspValid,
    output logic [15:0]         ab2s1_WrRsp,
    output logic [ADDR_LMT-1:0] ab2s1_WrRspAddr,
    input  logic                s12ab_TestCmp,
    output logic                tx_c0_valid,
    output logic [ADDR_LMT-1:0] tx_c0_addr,
    output logic [15:0]         tx_c0_mdata,
    input  logic                tx_c0_almfull,
    output logic                tx_c1_valid,
    output logic                tx_c1_fence,
    output logic [ADDR_LMT-1:0] tx_c1_addr,
    output logic [15:0]         tx_c1_mdata,
    output logic [511:0]        tx_c1_data,
    input  logic                tx_c1_almfull,
    input  logic                rx_c0_rdvalid,
    input  logic                rx_c0_umsgvalid,
    input  logic [15:0]         rx_c0_mdata,
    input  logic [511:0]        rx_c0_data,
    input  logic                rx_c1_wrvalid,
    input  logic [15:0]         rx_c1_mdata,
    output logic                arb_test_done,
    output logic                err_orphan_rsp
);
    localparam int IDX_W = $clog2(MAX_OUTST);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] ALM_LVL = CNT_W'(MAX_OUTST - PEND_THRESH);

    logic [MAX_OUTST-1:0] wv_q, wv_d, rv_q, rv_d;
    logic [IDX_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [ADDR_LMT-1:0]  waddr_mem [MAX_OUTST];
    logic [ADDR_LMT-1:0]  raddr_mem [MAX_OUTST];

    logic                tx_c0_valid_q, tx_c0_valid_d, rd_sent_q, rd_sent_d;
    logic [ADDR_LMT-1:0] tx_c0_addr_q, tx_c0_addr_d;
    logic [15:0]         tx_c0_mdata_q, tx_c0_mdata_d;
    logic                tx_c1_valid_q, tx_c1_valid_d, tx_c1_fence_q, tx_c1_fence_d;
    logic [ADDR_LMT-1:0] tx_c1_addr_q, tx_c1_addr_d;
    logic [15:0]         tx_c1_mdata_q, tx_c1_mdata_d;
    logic [511:0]        tx_c1_data_q, tx_c1_data_d;
    logic                wr_sent_q, wr_sent_d, wr_alm_q, wr_alm_d;
    logic                rd_rsp_vld_q, rd_rsp_vld_d, umsg_vld_q, umsg_vld_d;
    logic [15:0]         rd_rsp_q, rd_rsp_d;
    logic [ADDR_LMT-1:0] rd_rsp_addr_q, rd_rsp_addr_d;
    logic [511:0]        rd_data_q, rd_data_d;
    logic                wr_rsp_vld_q, wr_rsp_vld_d;
    logic [15:0]         wr_rsp_q, wr_rsp_d;
    logic [ADDR_LMT-1:0] wr_rsp_addr_q, wr_rsp_addr_d;
    logic                done_q, done_d, orphan_q, orphan_d;

    logic             wr_go, wr_alloc, rd_go, rd_hit, wr_hit, umsg_go;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             unused_tid_hi;

    assign unused_tid_hi = ^{s12ab_WrTID[15:8], s12ab_RdTID[15:8]};

    // The sent pulse blocks re-issue while the engine is still dropping its enable.
    assign wr_go    = s12ab_WrEn && !wr_sent_q && !tx_c1_almfull && !wv_q[wptr_q];
    assign wr_alloc = wr_go && !s12ab_WrFence;
    assign rd_go    = s12ab_RdEn && !rd_sent_q && !tx_c0_almfull && !rv_q[rptr_q];

    assign rd_idx  = rx_c0_mdata[IDX_W-1:0];
    assign wr_idx  = rx_c1_mdata[IDX_W-1:0];
    assign rd_hit  = rx_c0_rdvalid && ((rx_c0_mdata[7:0] >> IDX_W) == 8'd0) && rv_q[rd_idx];
    assign wr_hit  = rx_c1_wrvalid && ((rx_c1_mdata[7:0] >> IDX_W) == 8'd0) && wv_q[wr_idx];
    assign umsg_go = rx_c0_umsgvalid && !rx_c0_rdvalid;

    always_comb begin
        wv_d          = wv_q;
        rv_d          = rv_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        wcnt_d        = wcnt_q + {{(CNT_W-1){1'b0}}, wr_alloc} - {{(CNT_W-1){1'b0}}, wr_hit};
        rcnt_d        = rcnt_q + {{(CNT_W-1){1'b0}}, rd_go} - {{(CNT_W-1){1'b0}}, rd_hit};
        tx_c0_valid_d = rd_go;
        tx_c0_addr_d  = tx_c0_addr_q;
        tx_c0_mdata_d = tx_c0_mdata_q;
        rd_sent_d     = rd_go;
        tx_c1_valid_d = wr_go;
        tx_c1_fence_d = wr_go && s12ab_WrFence;
        tx_c1_addr_d  = tx_c1_addr_q;
        tx_c1_mdata_d = tx_c1_mdata_q;
        tx_c1_data_d  = tx_c1_data_q;
        wr_sent_d     = wr_go;
        wr_alm_d      = tx_c1_almfull || (wcnt_q >= ALM_LVL);
        rd_rsp_vld_d  = rd_hit;
        umsg_vld_d    = umsg_go;
        rd_rsp_q_hold: begin
            rd_rsp_d = rd_rsp_q;
        end
        rd_rsp_addr_d = rd_rsp_addr_q;
        rd_data_d     = rd_data_q;
        wr_rsp_vld_d  = wr_hit;
        wr_rsp_d      = wr_rsp_q;
        wr_rsp_addr_d = wr_rsp_addr_q;
        done_d        = done_q || (s12ab_TestCmp && (wcnt_q == '0) && (rcnt_q == '0));
        orphan_d      = orphan_q || (rx_c0_rdvalid && !rd_hit) || (rx_c1_wrvalid && !wr_hit);

        // Clears and allocations never collide: allocation only targets slots already invalid.
        if (wr_hit) begin
            wv_d[wr_idx]  = 1'b0;
            wr_rsp_d      = rx_c1_mdata;
            wr_rsp_addr_d = waddr_mem[wr_idx];
        end
        if (rd_hit) begin
            rv_d[rd_idx]  = 1'b0;
            rd_rsp_addr_d = raddr_mem[rd_idx];
        end
        if (rd_hit || umsg_go) begin
            rd_rsp_d  = rx_c0_mdata;
            rd_data_d = rx_c0_data;
        end
        if (wr_go) begin
            tx_c1_addr_d  = s12ab_WrAddr;
            tx_c1_mdata_d = s12ab_WrFence ? 16'h0000 : {s12ab_WrTID[7:0], 8'(wptr_q)};
            tx_c1_data_d  = 512'(s12ab_WrDin);
        end
        if (wr_alloc) begin
            wv_d[wptr_q] = 1'b1;
            wptr_d       = wptr_q + 1'b1;
        end
        if (rd_go) begin
            tx_c0_addr_d = s12ab_RdAddr;
            tx_c0_mdata_d = {s12ab_RdTID[7:0], 8'(rptr_q)};
            rv_d[rptr_q] = 1'b1;
            rptr_d       = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge Clk_400) begin
        if (test_Resetb && wr_alloc) waddr_mem[wptr_q] <= s12ab_WrAddr;
        if (test_Resetb && rd_go)    raddr_mem[rptr_q] <= s12ab_RdAddr;
    end

    always_ff @(posedge Clk_400) begin
        if (!test_Resetb) begin
            wv_q <= '0;            rv_q <= '0;
            wptr_q <= '0;          rptr_q <= '0;
            wcnt_q <= '0;          rcnt_q <= '0;
            tx_c0_valid_q <= 1'b0; tx_c0_addr_q <= '0;  tx_c0_mdata_q <= '0;
            rd_sent_q <= 1'b0;
            tx_c1_valid_q <= 1'b0; tx_c1_fence_q <= 1'b0;
            tx_c1_addr_q <= '0;    tx_c1_mdata_q <= '0; tx_c1_data_q <= '0;
            wr_sent_q <= 1'b0;     wr_alm_q <= 1'b0;
            rd_rsp_vld_q <= 1'b0;  umsg_vld_q <= 1'b0;
            rd_rsp_q <= '0;        rd_rsp_addr_q <= '0; rd_data_q <= '0;
            wr_rsp_vld_q <= 1'b0;  wr_rsp_q <= '0;      wr_rsp_addr_q <= '0;
            done_q <= 1'b0;        orphan_q <= 1'b0;
        end else begin
            wv_q <= wv_d;                   rv_q <= rv_d;
            wptr_q <= wptr_d;               rptr_q <= rptr_d;
            wcnt_q <= wcnt_d;               rcnt_q <= rcnt_d;
            tx_c0_valid_q <= tx_c0_valid_d; tx_c0_addr_q <= tx_c0_addr_d;
            tx_c0_mdata_q <= tx_c0_mdata_d; rd_sent_q <= rd_sent_d;
            tx_c1_valid_q <= tx_c1_valid_d; tx_c1_fence_q <= tx_c1_fence_d;
            tx_c1_addr_q <= tx_c1_addr_d;   tx_c1_mdata_q <= tx_c1_mdata_d;
            tx_c1_data_q <= tx_c1_data_d;
            wr_sent_q <= wr_sent_d;         wr_alm_q <= wr_alm_d;
            rd_rsp_vld_q <= rd_rsp_vld_d;   umsg_vld_q <= umsg_vld_d;
            rd_rsp_q <= rd_rsp_d;           rd_rsp_addr_q <= rd_rsp_addr_d;
            rd_data_q <= rd_data_d;
            wr_rsp_vld_q <= wr_rsp_vld_d;   wr_rsp_q <= wr_rsp_d;
            wr_rsp_addr_q <= wr_rsp_addr_d;
            done_q <= done_d;               orphan_q <= orphan_d;
        end
    end

    assign tx_c0_valid      = tx_c0_valid_q;
    assign tx_c0_addr       = tx_c0_addr_q;
    assign tx_c0_mdata      = tx_c0_mdata_q;
    assign ab2s1_RdSent     = rd_sent_q;
    assign tx_c1_valid      = tx_c1_valid_q;
    assign tx_c1_fence      = tx_c1_fence_q;
    assign tx_c1_addr       = tx_c1_addr_q;
    assign tx_c1_mdata      = tx_c1_mdata_q;
    assign tx_c1_data       = tx_c1_data_q;
    assign ab2s1_WrSent     = wr_sent_q;
    assign ab2s1_WrAlmFull  = wr_alm_q;
    assign ab2s1_RdRspValid = rd_rsp_vld_q;
    assign ab2s1_UMsgValid  = umsg_vld_q;
    assign ab2s1_RdRsp      = rd_rsp_q;
    assign ab2s1_RdRspAddr  = rd_rsp_addr_q;
    assign ab2s1_RdData     = rd_data_q;
    assign ab2s1_WrRspValid = wr_rsp_vld_q;
    assign ab2s1_WrRsp      = wr_rsp_q;
    assign ab2s1_WrRspAddr  = wr_rsp_addr_q;
    assign arb_test_done    = done_q;
    assign err_orphan_rsp   = orphan_q;
endmodule

// File: tb/tb_sw1_req_arb.sv
// Directed bench for sw1_req_arb: per-cycle comparison against a tag-table model plus literal spot checks.
module tb_sw1_req_arb;
    localparam int AW   = 20;
    localparam int MAXO = 16;
    localparam int THR  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstb = 1'b0;
    logic [AW-1:0] WrAddr = '0, RdAddr = '0;
    logic [15:0]   WrTID = '0, RdTID = '0;
    logic [20:0]   WrDin = '0;
    logic          WrFence = 1'b0, WrEn = 1'b0, RdEn = 1'b0, TestCmp = 1'b0;
    logic          c0_alm = 1'b0, c1_alm = 1'b0;
    logic          rdvalid = 1'b0, umsgvalid = 1'b0, wrvalid = 1'b0;
    logic [15:0]   rx0_mdata = '0, rx1_mdata = '0;
    logic [511:0]  rx0_data = '0;

    logic          WrSent, WrAlmFull, RdSent, RdRspValid, UMsgValid, WrRspValid;
    logic [15:0]   RdRsp, WrRsp, c0_mdata, c1_mdata;
    logic [AW-1:0] RdRspAddr, WrRspAddr, c0_addr, c1_addr;
    logic [511:0]  RdData, c1_data;
    logic          c0_valid, c1_valid, c1_fence, test_done, orphan;

    sw1_req_arb #(.ADDR_LMT(AW), .MAX_OUTST(MAXO), .PEND_THRESH(THR)) dut (
        .Clk_400(clk), .test_Resetb(rstb),
        .s12ab_WrAddr(WrAddr), .s12ab_WrTID(WrTID), .s12ab_WrDin(WrDin),
        .s12ab_WrFence(WrFence), .s12ab_WrEn(WrEn),
        .ab2s1_WrSent(WrSent), .ab2s1_WrAlmFull(WrAlmFull),
        .s12ab_RdAddr(RdAddr), .s12ab_RdTID(RdTID), .s12ab_RdEn(RdEn),
        .ab2s1_RdSent(RdSent), .ab2s1_RdRspValid(RdRspValid), .ab2s1_UMsgValid(UMsgValid),
        .ab2s1_RdRsp(RdRsp), .ab2s1_RdRspAddr(RdRspAddr), .ab2s1_RdData(RdData),
        .ab2s1_WrRspValid(WrRspValid), .ab2s1_WrRsp(WrRsp), .ab2s1_WrRspAddr(WrRspAddr),
        .s12ab_TestCmp(TestCmp),
        .tx_c0_valid(c0_valid), .tx_c0_addr(c0_addr), .tx_c0_mdata(c0_mdata),
        .tx_c0_almfull(c0_alm),
        .tx_c1_valid(c1_valid), .tx_c1_fence(c1_fence), .tx_c1_addr(c1_addr),
        .tx_c1_mdata(c1_mdata), .tx_c1_data(c1_data), .tx_c1_almfull(c1_alm),
        .rx_c0_rdvalid(rdvalid), .rx_c0_umsgvalid(umsgvalid), .rx_c0_mdata(rx0_mdata),
        .rx_c0_data(rx0_data), .rx_c1_wrvalid(wrvalid), .rx_c1_mdata(rx1_mdata),
        .arb_test_done(test_done), .err_orphan_rsp(orphan)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Model: per-channel slot arrays, wrap pointers and outstanding counts.
    bit            m_wv[MAXO], m_rv[MAXO];
    logic [AW-1:0] m_wa[MAXO], m_ra[MAXO];
    int            m_wp, m_rp, m_wc, m_rc;
    logic          e_c0v, e_rs, e_c1v, e_c1f, e_ws, e_walm, e_rrv, e_umv, e_wrv, e_done, e_orph;
    logic [AW-1:0] e_c0a, e_c1a, e_rra, e_wra;
    logic [15:0]   e_c0m, e_c1m, e_rr, e_wr;
    logic [511:0]  e_c1d, e_rd;

    always @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < MAXO; i++) begin m_wv[i] = 0; m_rv[i] = 0; end
            m_wp = 0; m_rp = 0; m_wc = 0; m_rc = 0;
            {e_c0v, e_rs, e_c1v, e_c1f, e_ws, e_walm, e_rrv, e_umv, e_wrv, e_done, e_orph} = '0;
            e_c0a = '0; e_c1a = '0; e_rra = '0; e_wra = '0;
            e_c0m = '0; e_c1m = '0; e_rr = '0; e_wr = '0; e_c1d = '0; e_rd = '0;
        end else begin
            int  rt, wt;
            bit  rhit, whit, wiss, riss;
            rt   = int'(rx0_mdata[7:0]);
            wt   = int'(rx1_mdata[7:0]);
            rhit = rdvalid && (rt < MAXO) && m_rv[rt % MAXO];
            whit = wrvalid && (wt < MAXO) && m_wv[wt % MAXO];
            wiss = WrEn && !e_ws && !c1_alm && !m_wv[m_wp];
            riss = RdEn && !e_rs && !c0_alm && !m_rv[m_rp];
            e_walm = c1_alm || (m_wc >= MAXO - THR);
            e_done = e_done || (TestCmp && m_wc == 0 && m_rc == 0);
            e_orph = e_orph || (rdvalid && !rhit) || (wrvalid && !whit);
            e_rrv = rhit;
            e_umv = umsgvalid && !rdvalid;
            e_wrv = whit;
            if (rhit) begin e_rra = m_ra[rt]; e_rr = rx0_mdata; e_rd = rx0_data; m_rv[rt] = 0; m_rc--; end
            if (e_umv) begin e_rr = rx0_mdata; e_rd = rx0_data; end
            if (whit) begin e_wra = m_wa[wt]; e_wr = rx1_mdata; m_wv[wt] = 0; m_wc--; end
            e_c1v = wiss; e_ws = wiss; e_c1f = wiss && WrFence;
            if (wiss) begin
                e_c1a = WrAddr;
                e_c1d = 512'(WrDin);
                e_c1m = WrFence ? 16'h0 : {WrTID[7:0], 8'(m_wp)};
                if (!WrFence) begin m_wv[m_wp] = 1; m_wa[m_wp] = WrAddr; m_wp = (m_wp + 1) % MAXO; m_wc++; end
            end
            e_c0v = riss; e_rs = riss;
            if (riss) begin
                e_c0a = RdAddr;
                e_c0m = {RdTID[7:0], 8'(m_rp)};
                m_rv[m_rp] = 1; m_ra[m_rp] = RdAddr; m_rp = (m_rp + 1) % MAXO; m_rc++;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("c0_valid", 64'(c0_valid), 64'(e_c0v));
            chk("rd_sent", 64'(RdSent), 64'(e_rs));
            chk("c1_valid", 64'(c1_valid), 64'(e_c1v));
            chk("wr_sent", 64'(WrSent), 64'(e_ws));
            chk("wr_almfull", 64'(WrAlmFull), 64'(e_walm));
            chk("rd_rsp_valid", 64'(RdRspValid), 64'(e_rrv));
            chk("umsg_valid", 64'(UMsgValid), 64'(e_umv));
            chk("wr_rsp_valid", 64'(WrRspValid), 64'(e_wrv));
            chk("test_done", 64'(test_done), 64'(e_done));
            chk("orphan", 64'(orphan), 64'(e_orph));
            if (e_c0v) begin
                chk("c0_addr", 64'(c0_addr), 64'(e_c0a));
                chk("c0_mdata", 64'(c0_mdata), 64'(e_c0m));
            end
            if (e_c1v) begin
                chk("c1_fence", 64'(c1_fence), 64'(e_c1f));
                chk("c1_addr", 64'(c1_addr), 64'(e_c1a));
                chk("c1_mdata", 64'(c1_mdata), 64'(e_c1m));
                chkw("c1_data", c1_data, e_c1d);
            end
            if (e_rrv) chk("rd_rsp_addr", 64'(RdRspAddr), 64'(e_rra));
            if (e_rrv || e_umv) begin
                chk("rd_rsp", 64'(RdRsp), 64'(e_rr));
                chkw("rd_data", RdData, e_rd);
            end
            if (e_wrv) begin
                chk("wr_rsp_addr", 64'(WrRspAddr), 64'(e_wra));
                chk("wr_rsp", 64'(WrRsp), 64'(e_wr));
            end
        end
    end

    task automatic do_reset();
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    initial begin
        int nrd, nws, alm_at, k, extra;
        repeat (2) @(negedge clk);
        chk("rst_c1_valid", 64'(c1_valid), 64'd0);
        chk("rst_done", 64'(test_done), 64'd0);
        rstb = 1'b1;

        // Single write then its response.
        WrAddr = 20'h0FFE0; WrTID = 16'h0020; WrDin = 21'd1; WrEn = 1'b1;
        @(negedge clk);
        chk("s1_c1_valid", 64'(c1_valid), 64'd1);
        chk("s1_c1_mdata", 64'(c1_mdata), 64'h2000);
        chk("s1_wrsent", 64'(WrSent), 64'd1);
        WrEn = 1'b0;
        wrvalid = 1'b1; rx1_mdata = 16'h2000;
        @(negedge clk);
        wrvalid = 1'b0;
        chk("s1_wrrsp_valid", 64'(WrRspValid), 64'd1);
        chk("s1_wrrsp_addr", 64'(WrRspAddr), 64'h0FFE0);

        // Read enable held two cycles issues once.
        RdAddr = 20'h0FFE0; RdTID = 16'h0020; RdEn = 1'b1; nrd = 0;
        repeat (2) begin @(negedge clk); if (c0_valid) nrd++; end
        RdEn = 1'b0;
        repeat (3) begin @(negedge clk); if (c0_valid) nrd++; end
        chk("s2_single_issue", 64'(nrd), 64'd1);
        rdvalid = 1'b1; rx0_mdata = 16'h2000; rx0_data = 512'd2;
        @(negedge clk);
        rdvalid = 1'b0;
        chk("s2_rdrsp_addr", 64'(RdRspAddr), 64'h0FFE0);
        chk("s2_rddata", 64'(RdData[20:0]), 64'd2);

        // Fill all 16 write tags; the 17th stalls until tag 0 returns.
        do_reset();
        WrTID = 16'h0031; WrAddr = 20'h00100; WrEn = 1'b1; nws = 0; alm_at = -1; k = 0;
        while (nws < 16 && k < 100) begin
            @(negedge clk); k++;
            if (WrAlmFull && alm_at < 0) alm_at = nws;
            if (WrSent) begin nws++; WrAddr = 20'h00100 + 20'(nws); end
        end
        chk("s3_sixteen_sent", 64'(nws), 64'd16);
        chk("s3_alm_at_15", 64'(alm_at), 64'd15);
        extra = 0;
        repeat (5) begin @(negedge clk); if (WrSent) extra++; end
        chk("s3_stalled", 64'(extra), 64'd0);
        chk("s3_almfull_hi", 64'(WrAlmFull), 64'd1);
        wrvalid = 1'b1; rx1_mdata = 16'h3100;
        @(negedge clk);
        wrvalid = 1'b0;
        k = 0;
        while (WrSent !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        chk("s3_17th_sent", 64'(WrSent), 64'd1);
        chk("s3_17th_mdata", 64'(c1_mdata), 64'h3100);
        chk("s3_17th_addr", 64'(c1_addr), 64'h00110);
        WrEn = 1'b0;

        // c0 almost-full holds the read off; then a fence beat.
        do_reset();
        c0_alm = 1'b1; RdEn = 1'b1; RdAddr = 20'h00222; RdTID = 16'h0044; nrd = 0;
        repeat (10) begin @(negedge clk); if (RdSent || c0_valid) nrd++; end
        chk("s4_no_issue", 64'(nrd), 64'd0);
        c0_alm = 1'b0;
        @(negedge clk);
        RdEn = 1'b0;
        chk("s4_issue", 64'(c0_valid), 64'd1);
        chk("s4_mdata", 64'(c0_mdata), 64'h4400);
        WrEn = 1'b1; WrFence = 1'b1; WrAddr = 20'h00333;
        @(negedge clk);
        WrEn = 1'b0; WrFence = 1'b0;
        chk("s4_fence", 64'(c1_fence), 64'd1);
        chk("s4_fence_mdata", 64'(c1_mdata), 64'h0000);

        // Read beats UMsg; a lone UMsg; a write response to an empty tag.
        chk("s5_orphan_lo", 64'(orphan), 64'd0);
        rdvalid = 1'b1; umsgvalid = 1'b1; rx0_mdata = 16'h4400; rx0_data = 512'h5A;
        @(negedge clk);
        rdvalid = 1'b0; umsgvalid = 1'b1; rx0_mdata = 16'hABCD;
        chk("s5_rd_wins", 64'(RdRspValid), 64'd1);
        chk("s5_umsg_dropped", 64'(UMsgValid), 64'd0);
        chk("s5_rd_addr", 64'(RdRspAddr), 64'h00222);
        @(negedge clk);
        umsgvalid = 1'b0;
        chk("s5_umsg", 64'(UMsgValid), 64'd1);
        chk("s5_umsg_hdr", 64'(RdRsp), 64'hABCD);
        wrvalid = 1'b1; rx1_mdata = 16'h0005;
        @(negedge clk);
        wrvalid = 1'b0;
        chk("s5_no_wrrsp", 64'(WrRspValid), 64'd0);
        chk("s5_orphan", 64'(orphan), 64'd1);

        // Mid-run reset with reads in flight, then completion and a stale response.
        do_reset();
        RdEn = 1'b1; RdTID = 16'h0055; RdAddr = 20'h00400; nrd = 0; k = 0;
        while (nrd < 3 && k < 20) begin @(negedge clk); k++; if (RdSent) nrd++; end
        RdEn = 1'b0;
        chk("s6_three_reads", 64'(nrd), 64'd3);
        TestCmp = 1'b1;
        @(negedge clk);
        TestCmp = 1'b0;
        chk("s6_not_done", 64'(test_done), 64'd0);
        do_reset();
        TestCmp = 1'b1;
        @(negedge clk);
        TestCmp = 1'b0;
        chk("s6_done", 64'(test_done), 64'd1);
        rdvalid = 1'b1; rx0_mdata = 16'h5501;
        @(negedge clk);
        rdvalid = 1'b0;
        chk("s6_stale_dropped", 64'(RdRspValid), 64'd0);
        chk("s6_stale_orphan", 64'(orphan), 64'd1);
        chk("s6_done_sticky", 64'(test_done), 64'd1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
